serial_frame_rx: RTL

- Receives asynchronous serial frames from a single line and delivers parallel bytes with status.
- Frame format: start (0), DATA_W data bits LSB first, one even-parity bit, stop (1).
- Pairs with the team's serial frame transmitter of the same format.
- Sits between the external rx pin and the byte consumer; oversamples the line with the system clock.

---
 rtl/serial_pkg.sv | 27 ++
 rtl/serial_frame_rx_if.sv | 26 ++
 rtl/serial_frame_rx_sync2.sv | 29 ++
 rtl/serial_frame_rx.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: state encoding, frame constants and even-parity helper shared by serial rx/tx.
// Rev 1.0
`default_nettype none

package serial_pkg;

   localparam int MAX_DATA_W = 16;
   localparam int DEF_DATA_W = 8;
   localparam int FRAME_BITS = DEF_DATA_W + 3;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_IDLE = 3'd5
   } state_t;

   // Parity bit value that makes the total count of ones even.
   function automatic logic even_parity(input logic [MAX_DATA_W-1:0] d);
      return ^d;
   endfunction

endpackage

`default_nettype wire

// File: rtl/serial_frame_rx_if.sv
// serial_frame_rx_if: serial line input and parallel byte/status outputs of the receiver.
// Rev 1.0
`default_nettype none

interface serial_frame_rx_if #(
   parameter int DATA_W = 8
);
   logic              rx_i;
   logic [DATA_W-1:0] data_o;
   logic              valid_o;
   logic              parity_err_o;
   logic              frame_err_o;
   logic              busy_o;

   modport master (
      output rx_i,
      input  data_o, valid_o, parity_err_o, frame_err_o, busy_o
   );

   modport slave (
      input  rx_i,
      output data_o, valid_o, parity_err_o, frame_err_o, busy_o
   );
endinterface

`default_nettype wire

// File: rtl/serial_frame_rx_sync2.sv
// sync2: two-flop synchronizer with configurable reset value.
// Rev 1.0
`default_nettype none

module sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);
   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;
endmodule

`default_nettype wire

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: oversampling receiver for start/DATA_W LSB-first/even-parity/stop frames.
// Rev 1.0
`default_nettype none

module serial_frame_rx
   import serial_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int OVS    = 4
) (
   input  logic              clk,
   input  logic              rst,
   serial_frame_rx_if.slave  bus
);
   localparam int PH_W  = $clog2(OVS);
   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [PH_W-1:0]  c_PH_HALF  = PH_W'(OVS/2 - 1);
   localparam logic [PH_W-1:0]  c_PH_FULL  = PH_W'(OVS - 1);
   localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(DATA_W - 1);

   logic w_rxs;

   state_t             r_state,  w_state;
   logic [PH_W-1:0]    r_phase,  w_phase;
   logic [IDX_W-1:0]   r_idx,    w_idx;
   logic [DATA_W-1:0]  r_shift,  w_shift;
   logic               r_perr,   w_perr;
   logic [DATA_W-1:0]  r_data,   w_data;
   logic               r_valid,  w_valid;
   logic               r_pe,     w_pe;
   logic               r_fe,     w_fe;
   logic               w_tick;

   sync2 #(.RST_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .i_d (bus.rx_i),
      .o_q (w_rxs)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_phase <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_perr  <= 1'b0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_pe    <= 1'b0;
         r_fe    <= 1'b0;
      end else begin
         r_state <= w_state;
         r_phase <= w_phase;
         r_idx   <= w_idx;
         r_shift <= w_shift;
         r_perr  <= w_perr;
         r_data  <= w_data;
         r_valid <= w_valid;
         r_pe    <= w_pe;
         r_fe    <= w_fe;
      end
   end

   assign w_tick = (r_phase == '0);

   always_comb begin
      w_state = r_state;
      w_phase = r_phase;
      w_idx   = r_idx;
      w_shift = r_shift;
      w_perr  = r_perr;
      w_data  = r_data;
      w_valid = 1'b0;
      w_pe    = 1'b0;
      w_fe    = 1'b0;

      case (r_state)
         IDLE: begin
            if (!w_rxs) begin
               w_state = START;
               w_phase = c_PH_HALF;
            end
         end
         START: begin
            if (!w_tick) begin
               w_phase = r_phase - PH_W'(1);
            end else if (w_rxs) begin
               w_state = IDLE;
            end else begin
               w_state = DATA;
               w_phase = c_PH_FULL;
               w_idx   = '0;
            end
         end
         DATA: begin
            if (!w_tick) begin
               w_phase = r_phase - PH_W'(1);
            end else begin
               w_shift[r_idx] = w_rxs;
               w_phase        = c_PH_FULL;
               if (r_idx == c_IDX_LAST) begin
                  w_state = PARITY;
               end else begin
                  w_idx = r_idx + IDX_W'(1);
               end
            end
         end
         PARITY: begin
            if (!w_tick) begin
               w_phase = r_phase - PH_W'(1);
            end else begin
               w_perr  = even_parity(MAX_DATA_W'(r_shift)) ^ w_rxs;
               w_phase = c_PH_FULL;
               w_state = STOP;
            end
         end
         STOP: begin
            if (!w_tick) begin
               w_phase = r_phase - PH_W'(1);
            end else if (w_rxs) begin
               w_state = IDLE;
               if (r_perr) begin
                  w_pe = 1'b1;
               end else begin
                  w_valid = 1'b1;
                  w_data  = r_shift;
               end
            end else begin
               // A low stop bit outranks any parity result and parks until the line idles.
               w_fe    = 1'b1;
               w_state = WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            if (w_rxs) begin
               w_state = IDLE;
            end
         end
         default: begin
            w_state = IDLE;
         end
      endcase
   end

   assign bus.data_o       = r_data;
   assign bus.valid_o      = r_valid;
   assign bus.parity_err_o = r_pe;
   assign bus.frame_err_o  = r_fe;
   assign bus.busy_o       = (r_state != IDLE);
endmodule

`default_nettype wire
